// File: rtl/if_id_skid_pkg.sv
// MIPS instruction field layout shared by the IF/ID register and the decoder,
// plus the helper that splits a raw word into its decode fields.
package if_id_skid_pkg;

  localparam int RAW_OPCODE_BUS = 6;
  localparam int RAW_RS_BUS     = 5;
  localparam int RAW_RT_BUS     = 5;
  localparam int RAW_RD_BUS     = 5;
  localparam int RAW_SHAMT_BUS  = 5;
  localparam int RAW_FUNCT_BUS  = 6;
  localparam int RAW_IMM_BUS    = 16;
  localparam int RAW_TARGET_BUS = 26;

  // LSB position of each field: the field is inst[INST_x_BUS +: RAW_x_BUS]
  localparam int INST_OPCODE_BUS = 26;
  localparam int INST_RS_BUS     = 21;
  localparam int INST_RT_BUS     = 16;
  localparam int INST_RD_BUS     = 11;
  localparam int INST_SHAMT_BUS  = 6;
  localparam int INST_FUNCT_BUS  = 0;
  localparam int INST_IMM_BUS    = 0;
  localparam int INST_TARGET_BUS = 0;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [RAW_OPCODE_BUS-1:0] opcode;
    logic [RAW_RS_BUS-1:0]     rs;
    logic [RAW_RT_BUS-1:0]     rt;
    logic [RAW_RD_BUS-1:0]     rd;
    logic [RAW_SHAMT_BUS-1:0]  sa;
    logic [RAW_FUNCT_BUS-1:0]  fn;
    logic [RAW_IMM_BUS-1:0]    imm;
    logic [RAW_TARGET_BUS-1:0] target;
  } id_fields_t;

  function automatic id_fields_t split_inst(input logic [31:0] inst);
    id_fields_t f;
    f.opcode = inst[INST_OPCODE_BUS +: RAW_OPCODE_BUS];
    f.rs     = inst[INST_RS_BUS     +: RAW_RS_BUS];
    f.rt     = inst[INST_RT_BUS     +: RAW_RT_BUS];
    f.rd     = inst[INST_RD_BUS     +: RAW_RD_BUS];
    f.sa     = inst[INST_SHAMT_BUS  +: RAW_SHAMT_BUS];
    f.fn     = inst[INST_FUNCT_BUS  +: RAW_FUNCT_BUS];
    f.imm    = inst[INST_IMM_BUS    +: RAW_IMM_BUS];
    f.target = inst[INST_TARGET_BUS +: RAW_TARGET_BUS];
    return f;
  endfunction

endpackage

// File: rtl/if_id_skid_if.sv
// Fetch-side handshake, ID-side control and decoded output bundle.
// master = fetch/hazard environment, slave = the IF/ID register.
interface if_id_skid_if
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                      if_valid;
  logic [ADDR_WIDTH-1:0]     if_pc;
  logic [31:0]               if_inst;
  logic                      if_ready;
  logic                      id_stall;
  logic                      id_flush;
  logic                      id_valid;
  logic [ADDR_WIDTH-1:0]     id_pc;
  logic [RAW_OPCODE_BUS-1:0] id_opcode;
  logic [RAW_RS_BUS-1:0]     id_rs;
  logic [RAW_RT_BUS-1:0]     id_rt;
  logic [RAW_RD_BUS-1:0]     id_rd;
  logic [RAW_SHAMT_BUS-1:0]  id_sa;
  logic [RAW_FUNCT_BUS-1:0]  id_fn;
  logic [RAW_IMM_BUS-1:0]    id_imm;
  logic [RAW_TARGET_BUS-1:0] id_target;
  logic [CNT_WIDTH-1:0]      buf_count;

  modport master (
    output if_valid, if_pc, if_inst, id_stall, id_flush,
    input  if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd,
           id_sa, id_fn, id_imm, id_target, buf_count
  );

  modport slave (
    input  if_valid, if_pc, if_inst, id_stall, id_flush,
    output if_ready, id_valid, id_pc, id_opcode, id_rs, id_rt, id_rd,
           id_sa, id_fn, id_imm, id_target, buf_count
  );

endinterface

// File: rtl/if_id_skid_skid_fifo.sv
// DEPTH-entry circular skid buffer; head is valid whenever count != 0.
// Push is ignored when full, pop when empty; clear empties it in one cycle.
module skid_fifo #(
  parameter  int DEPTH     = 2,
  parameter  int WIDTH     = 64,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit compare so non-power-of-2 depths wrap at DEPTH-1, not at 2**PTR_W-1
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID register with skid FIFO: 1-cycle fetch-to-ID latency when the FIFO is empty.
// if_ready drops only when the FIFO is full (registered), never from stall/flush.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic         clk,
  input logic         rst,
  if_id_skid_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int BEAT_W    = ADDR_WIDTH + 32;

  logic [BEAT_W-1:0]     fifo_head;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  push;
  logic                  pop;

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  id_fields_t            fld_q;
  logic                  valid_d;
  logic [ADDR_WIDTH-1:0] pc_d;
  id_fields_t            fld_d;

  assign fifo_empty  = (fifo_count == '0);
  assign accept      = bus.if_valid && !fifo_full;
  assign bus.if_ready = !fifo_full;

  skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (bus.id_flush),
    .din   ({bus.if_pc, bus.if_inst}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Priority: flush > stall > drain FIFO head > bypass new beat > bubble
  always_comb begin
    valid_d = 1'b0;
    pc_d    = '0;
    fld_d   = split_inst(NOP_INST);
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.id_flush) begin
      valid_d = 1'b0;
    end else if (bus.id_stall) begin
      valid_d = valid_q;
      pc_d    = pc_q;
      fld_d   = fld_q;
      push    = accept;
    end else if (!fifo_empty) begin
      valid_d = 1'b1;
      pc_d    = fifo_head[BEAT_W-1:32];
      fld_d   = split_inst(fifo_head[31:0]);
      pop     = 1'b1;
      push    = accept;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = bus.if_pc;
      fld_d   = split_inst(bus.if_inst);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      fld_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      fld_q   <= fld_d;
    end
  end

  assign bus.id_valid  = valid_q;
  assign bus.id_pc     = pc_q;
  assign bus.id_opcode = fld_q.opcode;
  assign bus.id_rs     = fld_q.rs;
  assign bus.id_rt     = fld_q.rt;
  assign bus.id_rd     = fld_q.rd;
  assign bus.id_sa     = fld_q.sa;
  assign bus.id_fn     = fld_q.fn;
  assign bus.id_imm    = fld_q.imm;
  assign bus.id_target = fld_q.target;
  assign bus.buf_count = fifo_count;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: vector table on a DEPTH=2 instance, reset corners,
// and a scoreboarded random-stall stream through a DEPTH=3 instance.
module tb_if_id_skid;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  if_id_skid_if #(.ADDR_WIDTH(32), .DEPTH(2)) b2 ();
  if_id_skid_if #(.ADDR_WIDTH(32), .DEPTH(3)) b3 ();

  if_id_skid #(.ADDR_WIDTH(32), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  if_id_skid #(.ADDR_WIDTH(32), .DEPTH(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    bit          stall;
    bit          flush;
    bit          vld;
    logic [31:0] pc;
    bit          e_vld;
    logic [31:0] e_pc;
    int          e_cnt;
    bit          e_rdy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(bit s, bit f, bit v, logic [31:0] pc,
                               bit ev, logic [31:0] epc, int ec, bit er);
    vec_t r;
    r.stall = s; r.flush = f; r.vld = v; r.pc = pc;
    r.e_vld = ev; r.e_pc = epc; r.e_cnt = ec; r.e_rdy = er;
    return r;
  endfunction

  // Instruction word tied to its pc so the bench can predict fields of any beat
  function automatic logic [31:0] mk(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h0109_5020;
    return 32'h8D00_0000 | (pc << 4) | pc;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input bit s, input bit f, input bit v, input logic [31:0] pc);
    b2.id_stall = s;
    b2.id_flush = f;
    b2.if_valid = v;
    b2.if_pc    = pc;
    b2.if_inst  = mk(pc);
  endtask

  task automatic chk_out2(input string tag, input bit e_vld, input logic [31:0] e_pc,
                          input int e_cnt, input bit e_rdy);
    logic [31:0] ei;
    ei = e_vld ? mk(e_pc) : 32'h0;
    chk({tag, ".valid"}, 64'(b2.id_valid), 64'(e_vld));
    chk({tag, ".pc"}, 64'(b2.id_pc), 64'(e_pc));
    chk({tag, ".count"}, 64'(b2.buf_count), 64'(e_cnt));
    chk({tag, ".ready"}, 64'(b2.if_ready), 64'(e_rdy));
    chk({tag, ".fields"}, 64'({b2.id_opcode, b2.id_rs, b2.id_rt, b2.id_rd, b2.id_sa, b2.id_fn}),
        64'(ei));
    chk({tag, ".imm"}, 64'(b2.id_imm), 64'(ei[15:0]));
    chk({tag, ".target"}, 64'(b2.id_target), 64'(ei[25:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nxt;
    int          popped;
    int          cyc;
    bit          st;
    logic [31:0] pcv;
    logic [31:0] e;
    logic [31:0] exp_q[$];

    b3.id_stall = 1'b0; b3.id_flush = 1'b0; b3.if_valid = 1'b0;
    b3.if_pc = '0; b3.if_inst = '0;
    drive2(1'b0, 1'b0, 1'b1, 32'h0);
    b2.if_inst = 32'h2408_0005;
    rst = 1'b1;

    // Reset with a beat offered: nothing may be captured
    tick();
    chk_out2("reset", 1'b0, 32'h0, 0, 1'b1);
    chk("reset.d3_valid", 64'(b3.id_valid), 64'(0));
    chk("reset.d3_count", 64'(b3.buf_count), 64'(0));
    rst = 1'b0;

    //         stall flush vld  pc       e_vld e_pc   cnt rdy
    tv.push_back(mkv(0, 0, 1, 32'h00, 1, 32'h00, 0, 1));
    tv.push_back(mkv(0, 0, 1, 32'h04, 1, 32'h04, 0, 1));
    tv.push_back(mkv(1, 0, 1, 32'h08, 1, 32'h04, 1, 1));
    tv.push_back(mkv(1, 0, 1, 32'h0C, 1, 32'h04, 2, 0));
    tv.push_back(mkv(1, 0, 1, 32'h10, 1, 32'h04, 2, 0));
    tv.push_back(mkv(0, 0, 1, 32'h10, 1, 32'h08, 1, 1));
    tv.push_back(mkv(0, 0, 1, 32'h10, 1, 32'h0C, 1, 1));
    tv.push_back(mkv(0, 0, 0, 32'h00, 1, 32'h10, 0, 1));
    tv.push_back(mkv(0, 0, 0, 32'h00, 0, 32'h00, 0, 1));
    tv.push_back(mkv(1, 0, 0, 32'h00, 0, 32'h00, 0, 1));
    tv.push_back(mkv(0, 0, 1, 32'h14, 1, 32'h14, 0, 1));
    tv.push_back(mkv(1, 0, 1, 32'h18, 1, 32'h14, 1, 1));
    tv.push_back(mkv(1, 0, 1, 32'h1C, 1, 32'h14, 2, 0));
    tv.push_back(mkv(1, 1, 1, 32'h20, 0, 32'h00, 0, 1));
    tv.push_back(mkv(1, 0, 1, 32'h24, 0, 32'h00, 1, 1));
    tv.push_back(mkv(1, 1, 1, 32'h28, 0, 32'h00, 0, 1));
    tv.push_back(mkv(0, 0, 1, 32'h2C, 1, 32'h2C, 0, 1));
    tv.push_back(mkv(0, 0, 1, 32'h30, 1, 32'h30, 0, 1));
    tv.push_back(mkv(0, 1, 1, 32'h34, 0, 32'h00, 0, 1));
    tv.push_back(mkv(0, 0, 0, 32'h00, 0, 32'h00, 0, 1));

    foreach (tv[i]) begin
      drive2(tv[i].stall, tv[i].flush, tv[i].vld, tv[i].pc);
      tick();
      chk_out2($sformatf("row%0d", i), tv[i].e_vld, tv[i].e_pc, tv[i].e_cnt, tv[i].e_rdy);
      if (i == 0) begin
        chk("add.opcode", 64'(b2.id_opcode), 64'(0));
        chk("add.rs", 64'(b2.id_rs), 64'(8));
        chk("add.rt", 64'(b2.id_rt), 64'(9));
        chk("add.rd", 64'(b2.id_rd), 64'(10));
        chk("add.fn", 64'(b2.id_fn), 64'(32'h20));
      end
    end

    // Reset while stalled with a full FIFO discards everything
    drive2(1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    drive2(1'b1, 1'b0, 1'b1, 32'h44);
    tick();
    chk("rstfull.count_before", 64'(b2.buf_count), 64'(2));
    drive2(1'b1, 1'b0, 1'b1, 32'h48);
    rst = 1'b1;
    tick();
    chk_out2("rstfull", 1'b0, 32'h0, 0, 1'b1);
    rst = 1'b0;
    drive2(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out2("rstfull.after", 1'b0, 32'h0, 0, 1'b1);

    // DEPTH=3 stream with random stalls: scoreboard checks order and no loss
    nxt = 0; popped = 0; cyc = 0;
    while ((nxt < 10 || exp_q.size() != 0) && cyc < 400) begin
      if (cyc < 4)       st = 1'b1;
      else if (nxt < 10) st = ($urandom_range(0, 2) != 0);
      else               st = ($urandom_range(0, 3) == 0);
      pcv = 32'h100 + 32'(nxt) * 4;
      b3.id_stall = st;
      b3.if_valid = (nxt < 10) && (cyc < 4 || $urandom_range(0, 3) != 0);
      b3.if_pc    = pcv;
      b3.if_inst  = mk(pcv);
      if (b3.if_valid && b3.if_ready) begin
        exp_q.push_back(pcv);
        nxt++;
      end
      tick();
      cyc++;
      chk("wrap.ready_rule", 64'(b3.if_ready), 64'(b3.buf_count < 3));
      if (!st && b3.id_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wrap.extra: got pc 0x%0h, expected no output", b3.id_pc);
        end else begin
          e = exp_q.pop_front();
          popped++;
          chk("wrap.pc", 64'(b3.id_pc), 64'(e));
          chk("wrap.imm", 64'(b3.id_imm), 64'(mk(e) & 32'hFFFF));
          chk("wrap.target", 64'(b3.id_target), 64'(mk(e) & 32'h03FF_FFFF));
        end
      end
    end
    b3.id_stall = 1'b0;
    b3.if_valid = 1'b0;
    chk("wrap.accepted", 64'(nxt), 64'(10));
    chk("wrap.popped", 64'(popped), 64'(10));
    chk("wrap.left", 64'(exp_q.size()), 64'(0));
    tick();
    chk("wrap.final_count", 64'(b3.buf_count), 64'(0));
    chk("wrap.final_valid", 64'(b3.id_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
